// File: rtl/czt_spi_ctrl_if.sv
// Command/status bundle between the CZT_SPI_Comm register bank
// and the SPI transaction sequencer.
interface czt_spi_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 8,
    parameter int LEN_WIDTH  = 6
);
    logic                  start;
    logic                  abort;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [LEN_WIDTH-1:0]  len;
    logic [DIV_WIDTH-1:0]  clk_div;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;
    logic                  done;

    modport master (
        output start, abort, tx_data, len, clk_div,
        input  rx_data, busy, done
    );

    modport slave (
        input  start, abort, tx_data, len, clk_div,
        output rx_data, busy, done
    );
endinterface

// File: rtl/czt_spi_ctrl.sv
// SPI Mode 0 transaction sequencer for the CZT readout link:
// one CS-framed transfer per start, MSB-first, registered pins.
module czt_spi_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 8,
    parameter int LEN_WIDTH  = 6
) (
    input  logic          s00_axi_aclk,
    input  logic          s00_axi_aresetn,
    czt_spi_ctrl_if.slave bus,
    output logic          spi_sclk,
    output logic          spi_cs_n,
    output logic          spi_mosi,
    input  logic          spi_miso
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                state, state_nx;
    logic [DIV_WIDTH:0]    cnt, cnt_nx;
    logic [DIV_WIDTH-1:0]  div_q, div_nx;
    logic [LEN_WIDTH-1:0]  n_q, n_nx, bits, bits_nx;
    logic [LEN_WIDTH-1:0]  n_eff, shamt, bits_inc;
    logic [DATA_WIDTH-1:0] tx_sh, tx_sh_nx, tx_al;
    logic [DATA_WIDTH-1:0] rx_sh, rx_sh_nx, rx_q, rx_nx;
    logic                  sclk_q, sclk_nx, cs_q, cs_nx;
    logic                  mosi_q, mosi_nx, busy_q, busy_nx;
    logic                  done_q, done_nx;
    logic                  half_end, last_bit;

    assign n_eff = (bus.len == '0 || bus.len > LEN_WIDTH'(DATA_WIDTH))
                 ? LEN_WIDTH'(DATA_WIDTH) : bus.len;
    assign shamt    = LEN_WIDTH'(DATA_WIDTH) - n_eff;
    assign tx_al    = bus.tx_data << shamt;
    assign half_end = (cnt == {1'b0, div_q});
    assign bits_inc = bits + 1'b1;
    assign last_bit = (bits_inc == n_q);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state  <= IDLE;
            cnt    <= '0;
            div_q  <= '0;
            n_q    <= '0;
            bits   <= '0;
            tx_sh  <= '0;
            rx_sh  <= '0;
            rx_q   <= '0;
            sclk_q <= 1'b0;
            cs_q   <= 1'b1;
            mosi_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            div_q  <= div_nx;
            n_q    <= n_nx;
            bits   <= bits_nx;
            tx_sh  <= tx_sh_nx;
            rx_sh  <= rx_sh_nx;
            rx_q   <= rx_nx;
            sclk_q <= sclk_nx;
            cs_q   <= cs_nx;
            mosi_q <= mosi_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = SETUP;
            SETUP:   if (half_end) state_nx = SHIFT;
            SHIFT:   if (half_end && sclk_q && last_bit) state_nx = HOLD;
            HOLD:    if (half_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.abort) state_nx = IDLE;
    end

    always_comb begin
        cnt_nx   = cnt + 1'b1;
        div_nx   = div_q;
        n_nx     = n_q;
        bits_nx  = bits;
        tx_sh_nx = tx_sh;
        rx_sh_nx = rx_sh;
        rx_nx    = rx_q;
        sclk_nx  = sclk_q;
        cs_nx    = cs_q;
        mosi_nx  = mosi_q;
        busy_nx  = busy_q;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (bus.start) begin
                    div_nx   = bus.clk_div;
                    n_nx     = n_eff;
                    bits_nx  = '0;
                    tx_sh_nx = tx_al;
                    rx_sh_nx = '0;
                    mosi_nx  = tx_al[DATA_WIDTH-1];
                    cs_nx    = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            SETUP: begin
                if (half_end) begin
                    cnt_nx   = '0;
                    sclk_nx  = 1'b1;
                    rx_sh_nx = {rx_sh[DATA_WIDTH-2:0], spi_miso};
                end
            end
            SHIFT: begin
                if (half_end) begin
                    cnt_nx = '0;
                    // falling edge shifts mosi; rising edge samples miso
                    if (sclk_q) begin
                        sclk_nx  = 1'b0;
                        bits_nx  = bits_inc;
                        tx_sh_nx = tx_sh << 1;
                        mosi_nx  = tx_sh[DATA_WIDTH-2];
                    end else begin
                        sclk_nx  = 1'b1;
                        rx_sh_nx = {rx_sh[DATA_WIDTH-2:0], spi_miso};
                    end
                end
            end
            HOLD: begin
                if (half_end) begin
                    cnt_nx  = '0;
                    cs_nx   = 1'b1;
                    busy_nx = 1'b0;
                    done_nx = 1'b1;
                    rx_nx   = rx_sh;
                end
            end
            default: cnt_nx = '0;
        endcase
        if (bus.abort) begin
            cnt_nx  = '0;
            rx_nx   = rx_q;
            sclk_nx = 1'b0;
            cs_nx   = 1'b1;
            mosi_nx = 1'b0;
            busy_nx = 1'b0;
            done_nx = 1'b0;
        end
    end

    assign bus.rx_data = rx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign spi_sclk    = sclk_q;
    assign spi_cs_n    = cs_q;
    assign spi_mosi    = mosi_q;
endmodule

// File: tb/tb_czt_spi_ctrl.sv
// Directed bench for czt_spi_ctrl: table of framed transfers
// plus abort, start-while-busy, back-to-back and reset cases.
module tb_czt_spi_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic miso = 1'b0;
    logic sclk, cs_n, mosi;

    always #5 clk = ~clk;

    czt_spi_ctrl_if #(
        .DATA_WIDTH(32), .DIV_WIDTH(8), .LEN_WIDTH(6)
    ) bus ();

    czt_spi_ctrl #(
        .DATA_WIDTH(32), .DIV_WIDTH(8), .LEN_WIDTH(6)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rst_n),
        .bus            (bus),
        .spi_sclk       (sclk),
        .spi_cs_n       (cs_n),
        .spi_mosi       (mosi),
        .spi_miso       (miso)
    );

    typedef struct {
        logic [31:0] tx;
        logic [5:0]  len;
        logic [7:0]  div;
        bit          lp;
        logic [31:0] pat;
        int          n;
        int          h;
        int          rise;
        int          dcyc;
        logic [31:0] rx;
        logic [31:0] mo;
    } vec_t;

    vec_t vt[6];

    int n_pass = 0;
    int n_chk  = 0;

    int r_first, r_nrise, r_done, r_ndone, r_hbad, r_csfall;
    logic [31:0] r_rx, r_mosi;
    logic r_go;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycle 1 is the observation right after the edge that samples start.
    task automatic run_frame(input logic [31:0] tx, input logic [5:0] ln,
                             input logic [7:0] dv, input bit lp,
                             input logic [31:0] pat, input int n,
                             input int h, input int s2cyc,
                             input logic [31:0] tx2);
        int cyc;
        int hi;
        bit prev;
        bit prev_cs;
        bit seen;
        r_first = 0; r_nrise = 0; r_done = 0; r_ndone = 0;
        r_hbad = 0; r_csfall = 0; r_rx = '0; r_mosi = '0;
        bus.tx_data = tx;
        bus.len = ln;
        bus.clk_div = dv;
        bus.start = 1'b1;
        miso = 1'b0;
        tick;
        bus.start = 1'b0;
        cyc = 1; hi = 0; prev = 1'b0; prev_cs = 1'b1; seen = 1'b0;
        r_go = (cs_n === 1'b0) && (bus.busy === 1'b1);
        while (cyc <= 1000) begin
            if (cs_n === 1'b0 && prev_cs) r_csfall++;
            if (sclk === 1'b1 && !prev) begin
                r_nrise++;
                if (r_nrise == 1) r_first = cyc;
                r_mosi = {r_mosi[30:0], mosi};
            end
            if (sclk === 1'b1) hi++;
            else begin
                if (prev && hi != h) r_hbad++;
                hi = 0;
            end
            if (bus.done === 1'b1) begin
                r_ndone++;
                if (!seen) begin
                    r_done = cyc;
                    r_rx = bus.rx_data;
                end
                seen = 1'b1;
            end
            if (seen && cyc >= r_done + 2) break;
            prev = (sclk === 1'b1);
            prev_cs = (cs_n === 1'b1);
            if (lp) miso = mosi;
            else miso = (r_nrise < n) ? pat[n-1-r_nrise] : 1'b0;
            if (cyc == s2cyc) begin
                bus.start = 1'b1;
                bus.tx_data = tx2;
            end else bus.start = 1'b0;
            tick;
            cyc++;
        end
        bus.start = 1'b0;
        miso = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nd;
        int bad;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.tx_data = '0;
        bus.len = '0;
        bus.clk_div = '0;

        vt[0] = '{32'h000000A5, 6'd8,  8'd1,   1'b1, 32'h0,
                  8,  2,   3,   35,  32'h000000A5, 32'h000000A5};
        vt[1] = '{32'hDEADBEEF, 6'd0,  8'd0,   1'b0, 32'h12345678,
                  32, 1,   2,   66,  32'h12345678, 32'hDEADBEEF};
        vt[2] = '{32'h00000000, 6'd1,  8'd3,   1'b0, 32'hFFFFFFFF,
                  1,  4,   5,   13,  32'h00000001, 32'h00000000};
        vt[3] = '{32'h00000001, 6'd1,  8'd255, 1'b0, 32'h0,
                  1,  256, 257, 769, 32'h00000000, 32'h00000001};
        vt[4] = '{32'h0F0F1234, 6'd40, 8'd0,   1'b1, 32'h0,
                  32, 1,   2,   66,  32'h0F0F1234, 32'h0F0F1234};
        vt[5] = '{32'hFFFFFABC, 6'd12, 8'd2,   1'b1, 32'h0,
                  12, 3,   4,   76,  32'h00000ABC, 32'h00000ABC};

        #12;
        chk("rst_pins", {29'd0, sclk, cs_n, mosi}, 32'h2);
        chk("rst_stat", {30'd0, bus.busy, bus.done}, 32'h0);
        chk("rst_rx", bus.rx_data, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick;

        for (int i = 0; i < 6; i++) begin
            run_frame(vt[i].tx, vt[i].len, vt[i].div, vt[i].lp,
                      vt[i].pat, vt[i].n, vt[i].h, -1, 32'h0);
            chk($sformatf("v%0d_go", i), {31'd0, r_go}, 32'h1);
            chk($sformatf("v%0d_rise", i), r_first, vt[i].rise);
            chk($sformatf("v%0d_nrise", i), r_nrise, vt[i].n);
            chk($sformatf("v%0d_hwidth", i), r_hbad, 0);
            chk($sformatf("v%0d_done_cyc", i), r_done, vt[i].dcyc);
            chk($sformatf("v%0d_ndone", i), r_ndone, 1);
            chk($sformatf("v%0d_rx", i), r_rx, vt[i].rx);
            chk($sformatf("v%0d_mosi", i), r_mosi, vt[i].mo);
            tick;
        end

        // abort mid-frame: rx keeps the 0xABC left by the last vector
        bus.tx_data = 32'h1234;
        bus.len = 6'd16;
        bus.clk_div = 8'd2;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            miso = mosi;
            tick;
        end
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        chk("abort_pins", {29'd0, sclk, cs_n, mosi}, 32'h2);
        chk("abort_busy", {31'd0, bus.busy}, 32'h0);
        nd = 0;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (bus.done === 1'b1) nd++;
            if (cs_n !== 1'b1 || sclk !== 1'b0) bad++;
            tick;
        end
        chk("abort_nodone", nd, 0);
        chk("abort_idle", bad, 0);
        chk("abort_rx", bus.rx_data, 32'h00000ABC);

        // second start with another tx while busy is ignored
        run_frame(32'h5A, 6'd8, 8'd1, 1'b1, 32'h0, 8, 2, 10, 32'hFF);
        chk("busy_ndone", r_ndone, 1);
        chk("busy_done_cyc", r_done, 35);
        chk("busy_csfall", r_csfall, 1);
        chk("busy_rx", r_rx, 32'h5A);
        chk("busy_mosi", r_mosi, 32'h5A);
        tick;

        // back-to-back frames: restart in the done cycle
        bus.tx_data = 32'h1;
        bus.len = 6'd1;
        bus.clk_div = 8'd0;
        miso = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (3) tick;
        chk("b2b_done", {30'd0, bus.done, cs_n}, 32'h3);
        chk("b2b_rx", bus.rx_data, 32'h1);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("b2b_restart", {30'd0, cs_n, bus.busy}, 32'h1);
        repeat (3) tick;
        chk("b2b_done2", {31'd0, bus.done}, 32'h1);
        miso = 1'b0;
        tick;

        // start and abort together in IDLE: abort wins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("sa_now", {30'd0, bus.busy, cs_n}, 32'h1);
        repeat (5) tick;
        chk("sa_later", {29'd0, bus.busy, cs_n, bus.done}, 32'h2);

        // asynchronous reset in the middle of SHIFT
        bus.tx_data = 32'hC3;
        bus.len = 6'd8;
        bus.clk_div = 8'd1;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int c = 1; c < 8; c++) begin
            miso = mosi;
            tick;
        end
        chk("pre_rst_busy", {30'd0, bus.busy, cs_n}, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pins", {29'd0, sclk, cs_n, mosi}, 32'h2);
        chk("mid_rst_stat", {30'd0, bus.busy, bus.done}, 32'h0);
        chk("mid_rst_rx", bus.rx_data, 32'h0);
        miso = 1'b0;
        #10;
        @(negedge clk) rst_n = 1'b1;
        tick;
        run_frame(32'hA5, 6'd8, 8'd1, 1'b1, 32'h0, 8, 2, -1, 32'h0);
        chk("post_rst_done", r_done, 35);
        chk("post_rst_rx", r_rx, 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
